// File: rtl/pwm_pkg.sv
// Shared helpers for the multi-channel PWM generator: duty width and
// saturating duty arithmetic used on the per-channel shadow registers.
package pwm_pkg;

    function automatic int dw_of(input int period);
        return $clog2(period + 1);
    endfunction

    // Arithmetic is done wider than the duty register, so a step past either end clamps instead of wrapping.
    function automatic int sat_inc(input int cur, input int step, input int period);
        int sum;
        sum = cur + step;
        return (sum > period) ? period : sum;
    endfunction

    function automatic int sat_dec(input int cur, input int step);
        int diff;
        diff = cur - step;
        return (diff < 0) ? 0 : diff;
    endfunction

endpackage

// File: rtl/pwm_btn_sync.sv
// Single-bit 2-flop synchroniser followed by a registered rising-edge detector.
// A 0->1 input sampled at edge k gives a one-cycle pulse seen at edge k+3.
module pwm_btn_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);
    logic s_p0, s_p1, s_p2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_p0  <= 1'b0;
            s_p1  <= 1'b0;
            s_p2  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s_p0  <= btn;
            s_p1  <= s_p0;
            s_p2  <= s_p1;
            pulse <= s_p1 & ~s_p2;
        end
    end

endmodule

// File: rtl/pwm_gen_multi.sv
// NCH-channel PWM generator with one shared period counter, optional phase
// staggering and shadowed duty registers that load only at each channel's boundary.
module pwm_gen_multi
    import pwm_pkg::*;
#(
    parameter int  NCH       = 4,
    parameter int  PERIOD    = 10,
    parameter int  STEP      = 1,
    parameter int  DUTY_INIT = 5,
    parameter int  STAGGER   = 0,
    localparam int DW        = dw_of(PERIOD)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    inc,
    input  logic [NCH-1:0]    dec,
    output logic [NCH-1:0]    pwm,
    output logic [NCH*DW-1:0] duty_o,
    output logic              wrap
);
    localparam logic [DW-1:0] LAST  = DW'(PERIOD - 1);
    localparam logic [DW:0]   PER_X = (DW + 1)'(PERIOD);
    localparam logic [DW-1:0] INIT  = DW'(DUTY_INIT);

    logic [DW-1:0]  cnt;
    logic [NCH-1:0] inc_p;
    logic [NCH-1:0] dec_p;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else begin
            cnt  <= (cnt == LAST) ? '0 : cnt + DW'(1);
            wrap <= (cnt == LAST);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        localparam logic [DW:0] OFF = (STAGGER != 0) ? (DW + 1)'(i * (PERIOD / NCH)) : '0;

        logic [DW:0]   sum;
        logic [DW-1:0] ph;
        logic [DW-1:0] shadow;
        logic [DW-1:0] act;
        logic          pwm_r;

        pwm_btn_sync u_inc (.clk(clk), .rst_n(rst_n), .btn(inc[i]), .pulse(inc_p[i]));
        pwm_btn_sync u_dec (.clk(clk), .rst_n(rst_n), .btn(dec[i]), .pulse(dec_p[i]));

        // OFF < PERIOD and cnt < PERIOD, so one conditional subtract reduces the sum mod PERIOD.
        always_comb begin
            sum = {1'b0, cnt} + OFF;
            ph  = (sum >= PER_X) ? DW'(sum - PER_X) : sum[DW-1:0];
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                shadow <= INIT;
                act    <= INIT;
                pwm_r  <= 1'b0;
            end else begin
                if (inc_p[i] && !dec_p[i]) begin
                    shadow <= DW'(sat_inc(int'(shadow), STEP, PERIOD));
                end else if (dec_p[i] && !inc_p[i]) begin
                    shadow <= DW'(sat_dec(int'(shadow), STEP));
                end
                // Load reads the pre-update shadow; a same-cycle event waits for the next boundary.
                if (ph == LAST) begin
                    act <= shadow;
                end
                pwm_r <= (ph < act);
            end
        end

        assign pwm[i]              = pwm_r;
        assign duty_o[i*DW +: DW]  = act;
    end

endmodule

// File: tb/tb_pwm_gen_multi.sv
// Bench for pwm_gen_multi: an aligned (PERIOD=10) and a staggered (PERIOD=12)
// instance share stimulus and are compared each cycle against a behavioural model.
`timescale 1ns/1ps
module tb_pwm_gen_multi;
    localparam int NCH = 4;
    localparam int DW  = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NCH-1:0]      inc, dec;
    logic [NCH-1:0]      pwm_a, pwm_b;
    logic [NCH*DW-1:0]   duty_a, duty_b;
    logic                wrap_a, wrap_b;

    always #5 clk = ~clk;

    pwm_gen_multi #(.NCH(4), .PERIOD(10), .STEP(1), .DUTY_INIT(5), .STAGGER(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec),
        .pwm(pwm_a), .duty_o(duty_a), .wrap(wrap_a)
    );

    pwm_gen_multi #(.NCH(4), .PERIOD(12), .STEP(1), .DUTY_INIT(5), .STAGGER(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec),
        .pwm(pwm_b), .duty_o(duty_b), .wrap(wrap_b)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    // Behavioural model: time since reset, phase = (t + offset) mod PERIOD,
    // inputs become events three edges after a sampled rising edge.
    int             m_cyc;
    int             m_sh  [2][NCH];
    int             m_act [2][NCH];
    logic [NCH-1:0] m_pwm [2];
    logic           m_wrap[2];
    logic [NCH-1:0] h_inc [4];
    logic [NCH-1:0] h_dec [4];
    bit             m_valid = 1'b0;

    always @(posedge clk) begin
        int  p, off, ph;
        bit  ei, ed;
        if (!rst_n) begin
            m_cyc = 0;
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < NCH; i++) begin
                    m_sh[k][i]  = 5;
                    m_act[k][i] = 5;
                end
                m_pwm[k]  = '0;
                m_wrap[k] = 1'b0;
            end
            for (int j = 0; j < 4; j++) begin
                h_inc[j] = '0;
                h_dec[j] = '0;
            end
            m_valid = 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                p = (k == 0) ? 10 : 12;
                for (int i = 0; i < NCH; i++) begin
                    off = (k == 0) ? 0 : i * (p / NCH);
                    ph  = (m_cyc + off) % p;
                    m_pwm[k][i] = (ph < m_act[k][i]);
                    if (ph == p - 1) m_act[k][i] = m_sh[k][i];
                    ei = h_inc[2][i] && !h_inc[3][i];
                    ed = h_dec[2][i] && !h_dec[3][i];
                    if (ei && !ed)      m_sh[k][i] = (m_sh[k][i] + 1 > p) ? p : m_sh[k][i] + 1;
                    else if (ed && !ei) m_sh[k][i] = (m_sh[k][i] - 1 < 0) ? 0 : m_sh[k][i] - 1;
                end
                m_wrap[k] = ((m_cyc % p) == p - 1);
            end
            for (int j = 3; j > 0; j--) begin
                h_inc[j] = h_inc[j-1];
                h_dec[j] = h_dec[j-1];
            end
            h_inc[0] = inc;
            h_dec[0] = dec;
            m_cyc++;
        end
    end

    logic [NCH*DW-1:0] exp_duty;
    always @(negedge clk) begin
        if (m_valid) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < NCH; i++) exp_duty[i*DW +: DW] = DW'(m_act[k][i]);
                if (k == 0) begin
                    check("model_pwm_a",  32'(pwm_a),  32'(m_pwm[0]));
                    check("model_duty_a", 32'(duty_a), 32'(exp_duty));
                    check("model_wrap_a", 32'(wrap_a), 32'(m_wrap[0]));
                end else begin
                    check("model_pwm_b",  32'(pwm_b),  32'(m_pwm[1]));
                    check("model_duty_b", 32'(duty_b), 32'(exp_duty));
                    check("model_wrap_b", 32'(wrap_b), 32'(m_wrap[1]));
                end
            end
        end
    end

    task automatic pulse(input int ch, input bit up, input bit dn);
        @(negedge clk);
        inc[ch] = up;
        dec[ch] = dn;
        repeat (4) @(negedge clk);
        inc[ch] = 1'b0;
        dec[ch] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic count_high(input int ch, output int n);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (pwm_a[ch]) n++;
        end
    endtask

    task automatic wait_wrap(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 30 && !ok; n++) begin
            @(negedge clk);
            if (wrap_a) ok = 1'b1;
        end
    endtask

    logic [NCH-1:0] hb[40];

    initial begin
        int n, bad;
        bit ok;
        rst_n = 1'b0;
        inc   = '0;
        dec   = '0;
        repeat (3) @(negedge clk);
        check("reset_pwm",  32'(pwm_a),  32'h0);
        check("reset_duty", 32'(duty_a), 32'h5555);
        check("reset_wrap", 32'(wrap_a), 32'h0);
        rst_n = 1'b1;

        // Staggered instance: channel i leads channel 0 by 3*i cycles.
        repeat (4) @(negedge clk);
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            hb[t] = pwm_b;
        end
        n = 0;
        for (int t = 0; t < 12; t++) if (hb[t][0]) n++;
        check("stagger_high_ch0", 32'(n), 32'd5);
        for (int i = 1; i < NCH; i++) begin
            bad = 0;
            for (int t = 0; t < 24; t++) if (hb[t][i] !== hb[t + 3*i][0]) bad++;
            check($sformatf("stagger_ch%0d", i), 32'(bad), 32'd0);
        end

        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (wrap_a) n++;
        end
        check("wrap_count_20", 32'(n), 32'd2);
        count_high(0, n);
        check("default_high_ch0", 32'(n), 32'd5);

        // Increment ch0 with cnt==4 at the sampling edge: boundary five edges later.
        wait_wrap(ok);
        check("wrap_seen", 32'(ok), 32'd1);
        repeat (4) @(negedge clk);
        inc[0] = 1'b1;
        repeat (5) @(negedge clk);
        check("ch0_before_boundary", 32'(duty_a[3:0]), 32'd5);
        @(negedge clk);
        check("ch0_after_boundary", 32'(duty_a[3:0]), 32'd6);
        inc[0] = 1'b0;
        repeat (12) @(negedge clk);
        count_high(0, n);
        check("ch0_high_6", 32'(n), 32'd6);
        count_high(1, n);
        check("ch1_high_5", 32'(n), 32'd5);

        for (int r = 0; r < 7; r++) pulse(1, 1'b1, 1'b0);
        repeat (30) @(negedge clk);
        check("ch1_sat_hi", 32'(duty_a[7:4]), 32'd10);
        count_high(1, n);
        check("ch1_const_hi", 32'(n), 32'd10);
        for (int r = 0; r < 12; r++) pulse(1, 1'b0, 1'b1);
        repeat (30) @(negedge clk);
        check("ch1_sat_lo", 32'(duty_a[7:4]), 32'd0);
        count_high(1, n);
        check("ch1_const_lo", 32'(n), 32'd0);

        pulse(2, 1'b1, 1'b1);
        repeat (30) @(negedge clk);
        check("ch2_both", 32'(duty_a[11:8]), 32'd5);
        inc[2] = 1'b1;
        repeat (50) @(negedge clk);
        inc[2] = 1'b0;
        repeat (30) @(negedge clk);
        check("ch2_held", 32'(duty_a[11:8]), 32'd6);

        for (int r = 0; r < 3; r++) pulse(3, 1'b1, 1'b0);
        repeat (30) @(negedge clk);
        check("ch3_eight", 32'(duty_a[15:12]), 32'd8);

        // Edge in flight through the synchroniser when reset hits.
        @(negedge clk);
        inc[3] = 1'b1;
        @(negedge clk);
        inc[3] = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        check("midreset_pwm",  32'(pwm_a),  32'h0);
        check("midreset_duty", 32'(duty_a), 32'h5555);
        rst_n = 1'b1;
        repeat (9) @(negedge clk);
        check("midreset_nowrap", 32'(wrap_a), 32'd0);
        @(negedge clk);
        check("midreset_wrap", 32'(wrap_a), 32'd1);
        repeat (30) @(negedge clk);
        check("midreset_discard", 32'(duty_a[15:12]), 32'd5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pwm_gen_multi.md
Name: pwm_gen_multi

Overview:
- Multi-channel successor of the single-channel PWM generator: NCH independent PWM outputs sharing one period counter, each with its own debounced-free inc/dec button pair.
- Adds a parametrised period, step size and initial duty, plus optional phase staggering between channels.
- Adds shadowed, glitch-free duty updates that only take effect at a channel's period boundary.
- Sits between board-level push-button inputs and LED/motor drive pins.

Parameters:
- NCH, 4: number of PWM channels (1..16).
- PERIOD, 10: PWM period in clk cycles (2..255); output frequency is f_clk/PERIOD.
- STEP, 1: duty change per inc/dec event, in clk cycles (1..PERIOD).
- DUTY_INIT, 5: duty after reset, in clk cycles (0..PERIOD).
- STAGGER, 0: 1 = channel i phase offset of i*(PERIOD/NCH) cycles (integer division); 0 = all channels aligned.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- inc  in  NCH  async per-channel increment request (level; rising edge counts).
- dec  in  NCH  async per-channel decrement request (level; rising edge counts).
- pwm  out  NCH  registered PWM outputs.
- duty_o  out  NCH*DW  active duty per channel, channel i at [i*DW +: DW], DW = $clog2(PERIOD+1).
- wrap  out  1  one-cycle pulse registered alongside cnt==PERIOD-1 (shared counter end of period).

Behaviour:
- Reset (rst_n==0 at posedge): sync/edge flops 0, cnt 0, duty_shadow and duty_act all DUTY_INIT, pwm 0, wrap 0. Reset mid-period aborts the period; the first post-reset period starts with cnt==0.
- Input path per inc/dec bit: 2-flop synchroniser, then registered rising-edge detect. A 0->1 input seen at posedge k produces an internal one-cycle pulse valid at posedge k+3. A level held high gives exactly one event.
- Shadow update per channel, each cycle:
  - inc pulse only: shadow = min(shadow+STEP, PERIOD).
  - dec pulse only: shadow = max(shadow-STEP, 0).
  - Both pulses in the same cycle: no change.
  - Saturation is computed in DW+1 bits; shadow never wraps.
- Counter: cnt runs 0..PERIOD-1 then back to 0, free-running. Per-channel phase ph_i = (cnt + off_i) mod PERIOD, with off_i = STAGGER ? i*(PERIOD/NCH) : 0. ph_i is computed without a divider, using compare-and-subtract.
- Active duty: duty_act[i] <= duty_shadow[i] on the cycle where ph_i == PERIOD-1. A change therefore appears from the next period of that channel; no partial-period glitch.
- Output: pwm[i] <= (ph_i < duty_act[i]), registered, so pwm lags ph_i by 1 cycle. duty 0 gives constant low; duty PERIOD gives constant high with no gap at wrap.
- duty_o reflects duty_act (not shadow). wrap is registered, asserted the cycle after cnt==PERIOD-1.
- Events arriving in the same cycle as an active-duty load go to the shadow and apply at the following boundary.

Decomposition:
- Package pwm_pkg: function clog2-based DW helper and saturating add/sub functions (sat_inc, sat_dec), parametrised by PERIOD.
- Sub-module pwm_btn_sync: 1-bit 2-flop synchroniser plus registered rising-edge detect, output pulse. Instantiated 2*NCH times via generate.
- Top holds the counter, phase offsets, shadow/active registers and output flops.

Test Plan:
- Reset, defaults (NCH=4, PERIOD=10, STAGGER=0): every channel shows pwm high 5 / low 5 cycles per period; wrap pulses every 10 cycles; duty_o = 5 per channel.
- Single inc pulse on ch0 mid-period: ch0 duty_o becomes 6 at the first boundary after posedge k+3; next period has high 6 / low 4; channels 1-3 unchanged.
- Saturation: 7 inc edges on ch1 gives duty 10, pwm constantly 1. Then 12 dec edges gives duty 0, pwm constantly 0; duty_o never exceeds 10 or wraps below 0.
- Simultaneous inc and dec edges on ch2 in the same cycle: duty stays 5. Then an inc held high for 50 cycles gives exactly one step (duty 6).
- STAGGER=1, NCH=4, PERIOD=12: rising edges of pwm[0..3] are 3 cycles apart; each channel's duty update lands on its own boundary.
- Reset asserted mid-period with duty 8 on ch3: the next cycle gives pwm 0, duty_o 5, cnt 0. Inc pulses in flight through the synchroniser are discarded.
